// File: rtl/minimig_m68k_pkg.sv
// Shared types and constants for the Minimig 68000 bus master.
// The optional S4 timeout is built only when MINIMIG_M68K_MASTER_TIMEOUT_EN is defined.
package minimig_m68k_pkg;

    localparam int unsigned M68K_TIMEOUT_DEF = 255;
    localparam int unsigned M68K_TO_W        = 8;
    localparam int unsigned M68K_ADR_W       = 23;
    localparam int unsigned M68K_DAT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S2   = 3'd1,
        ST_S4   = 3'd2,
        ST_S6   = 3'd3,
        ST_S7   = 3'd4
    } m68k_state_e;

    // Request fields held for the duration of one bus cycle.
    typedef struct packed {
        logic                  we;
        logic [1:0]            bs;
        logic [M68K_DAT_W-1:0] wdat;
    } m68k_req_t;

endpackage

// File: rtl/minimig_m68k_sync.sv
// Single-stage input registers for the asynchronous _dtack/_berr bus responses.
module minimig_m68k_sync (
    input  logic clk,
    input  logic _reset,
    input  logic _dtack,
    input  logic _berr,
    output logic l_dtack,
    output logic l_berr
);

    // Reset to the negated level so a reset never looks like a bus response.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            l_dtack <= 1'b1;
            l_berr  <= 1'b1;
        end else begin
            l_dtack <= _dtack;
            l_berr  <= _berr;
        end
    end

endmodule

// File: rtl/minimig_m68k_master.sv
// 68000 bus master: turns a req/ack handshake into IDLE-S2-S4-S6-S7 bus cycles on clk7_en ticks.
// Define MINIMIG_M68K_MASTER_TIMEOUT_EN to add a bus-error timeout while waiting in S4.
module minimig_m68k_master
    import minimig_m68k_pkg::*;
#(
    parameter int unsigned TIMEOUT = M68K_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk7_en,
    input  logic        req,
    input  logic        req_we,
    input  logic [22:0] req_adr,
    input  logic [1:0]  req_bs,
    input  logic [15:0] req_wdat,
    output logic        req_ack,
    output logic        req_berr,
    output logic [15:0] req_rdat,
    output logic        _as,
    output logic        _uds,
    output logic        _lds,
    output logic        r_w,
    output logic [22:0] address,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    input  logic        _dtack,
    input  logic        _berr
);

    if (TIMEOUT == 0 || TIMEOUT >= (1 << M68K_TO_W)) begin : g_timeout_range
        $error("TIMEOUT must fit the timeout counter and be non-zero");
    end

    m68k_state_e state_q;
    m68k_req_t   cur_q;
    logic        berr_flag_q;
    logic        l_dtack;
    logic        l_berr;
    logic        to_hit;

    minimig_m68k_sync u_sync (
        .clk     (clk),
        ._reset  (_reset),
        ._dtack  (_dtack),
        ._berr   (_berr),
        .l_dtack (l_dtack),
        .l_berr  (l_berr)
    );

`ifdef MINIMIG_M68K_MASTER_TIMEOUT_EN
    logic [M68K_TO_W-1:0] to_cnt_q;

    // to_hit marks the TIMEOUT-th S4 tick without a bus response.
    assign to_hit = ((M68K_TO_W+1)'(to_cnt_q) + (M68K_TO_W+1)'(1)) >= (M68K_TO_W+1)'(TIMEOUT);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            to_cnt_q <= '0;
        end else if (clk7_en) begin
            if (state_q == ST_S4 && l_berr && l_dtack && !to_hit) begin
                to_cnt_q <= to_cnt_q + M68K_TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Bus cycle sequencer; every output is a register updated on clk7_en ticks.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            berr_flag_q <= 1'b0;
            address     <= '0;
            r_w         <= 1'b1;
            _as         <= 1'b1;
            _uds        <= 1'b1;
            _lds        <= 1'b1;
            data_oe     <= 1'b0;
            data_out    <= '0;
            req_ack     <= 1'b0;
            req_berr    <= 1'b0;
            req_rdat    <= '0;
        end else begin
            req_ack  <= 1'b0;
            req_berr <= 1'b0;
            if (clk7_en) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (req && !req_ack) begin
                            cur_q   <= '{we: req_we, bs: req_bs, wdat: req_wdat};
                            address <= req_adr;
                            r_w     <= !req_we;
                            state_q <= ST_S2;
                        end
                    end
                    ST_S2: begin
                        // Data strobes of either direction land together with _as on S4 entry.
                        _as  <= 1'b0;
                        _uds <= !cur_q.bs[1];
                        _lds <= !cur_q.bs[0];
                        if (cur_q.we) begin
                            data_oe  <= 1'b1;
                            data_out <= cur_q.wdat;
                        end
                        state_q <= ST_S4;
                    end
                    ST_S4: begin
                        if (!l_berr || (l_dtack && to_hit)) begin
                            berr_flag_q <= 1'b1;
                            state_q     <= ST_S7;
                        end else if (!l_dtack) begin
                            state_q <= ST_S6;
                        end
                    end
                    ST_S6: begin
                        if (!cur_q.we) begin
                            req_rdat <= data_in;
                        end
                        state_q <= ST_S7;
                    end
                    ST_S7: begin
                        _as         <= 1'b1;
                        _uds        <= 1'b1;
                        _lds        <= 1'b1;
                        data_oe     <= 1'b0;
                        r_w         <= 1'b1;
                        req_ack     <= 1'b1;
                        req_berr    <= berr_flag_q;
                        berr_flag_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minimig_m68k_master.sv
// Self-checking bench for minimig_m68k_master: directed table, randomized cycles against a
// transaction-level latency/data model, plus timeout, back-to-back and mid-cycle reset sequences.
module tb_minimig_m68k_master;

`ifdef MINIMIG_M68K_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam bit TB_TO_EN   = 1'b1;
`else
    localparam int TB_TIMEOUT = 255;
    localparam bit TB_TO_EN   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk7_en;
    logic        req;
    logic        req_we;
    logic [22:0] req_adr;
    logic [1:0]  req_bs;
    logic [15:0] req_wdat;
    logic        req_ack;
    logic        req_berr;
    logic [15:0] req_rdat;
    logic        as_n, uds_n, lds_n, r_w;
    logic [22:0] address;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        dtack_n;
    logic        berr_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [22:0] adr;
        logic [1:0]  bs;
        logic [15:0] wdat;
        logic [15:0] din;
        int          d;         // S4 ticks that see no response before _dtack/_berr
        bit          berr;      // _berr asserted together with _dtack
        int          lat;       // ticks from acceptance to the ack tick
        bit          exp_berr;
        logic [15:0] exp_rdat;
    } vec_t;

    minimig_m68k_master #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk      (clk),
        ._reset   (rst_n),
        .clk7_en  (clk7_en),
        .req      (req),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_bs   (req_bs),
        .req_wdat (req_wdat),
        .req_ack  (req_ack),
        .req_berr (req_berr),
        .req_rdat (req_rdat),
        ._as      (as_n),
        ._uds     (uds_n),
        ._lds     (lds_n),
        .r_w      (r_w),
        .address  (address),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in),
        ._dtack   (dtack_n),
        ._berr    (berr_n)
    );

    always #5 clk = ~clk;

    // 7 MHz enable: one clk in four, changed on the falling edge.
    initial begin
        logic [1:0] ph;
        ph      = 2'd0;
        clk7_en = 1'b0;
        forever begin
            @(negedge clk);
            ph      = ph + 2'd1;
            clk7_en = (ph == 2'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!clk7_en) @(posedge clk);
        #1;
    endtask

    // Expected outcome of one cycle from the bus rules; rd carries the last read data.
    function automatic void model(inout vec_t v, inout logic [15:0] rd);
        if (!TB_TO_EN || v.d < TB_TIMEOUT) begin
            if (v.berr) begin
                v.lat      = 3 + v.d;
                v.exp_berr = 1'b1;
            end else begin
                v.lat      = 4 + v.d;
                v.exp_berr = 1'b0;
                if (!v.we) rd = v.din;
            end
        end else begin
            v.lat      = 2 + TB_TIMEOUT;
            v.exp_berr = 1'b1;
        end
        v.exp_rdat = rd;
    endfunction

    task automatic run_txn(input vec_t v, input bit keep_req, input bit early_drop);
        req      = 1'b1;
        req_we   = v.we;
        req_adr  = v.adr;
        req_bs   = v.bs;
        req_wdat = v.wdat;
        data_in  = v.din;
        dtack_n  = 1'b1;
        berr_n   = 1'b1;
        wait_tick();
        chk("acc_adr", 32'(address), 32'(v.adr));
        chk("acc_rw", 32'(r_w), 32'(!v.we));
        chk("acc_as", 32'(as_n), 32'd1);
        if (early_drop) req = 1'b0;
        for (int k = 1; k <= v.lat; k++) begin
            wait_tick();
            if (k == 1 + v.d) begin
                dtack_n = 1'b0;
                if (v.berr) berr_n = 1'b0;
            end
            if (k == 1) begin
                chk("s2_as", 32'(as_n), 32'd0);
                chk("s2_uds", 32'(uds_n), 32'(!v.bs[1]));
                chk("s2_lds", 32'(lds_n), 32'(!v.bs[0]));
                if (v.we) chk("s2_dout", 32'(data_out), 32'(v.wdat));
            end
            if (k < v.lat) begin
                chk("wait_ack", 32'(req_ack), 32'd0);
                chk("wait_as", 32'(as_n), 32'd0);
                chk("wait_oe", 32'(data_oe), 32'(v.we));
                chk("wait_adr", 32'(address), 32'(v.adr));
                chk("wait_rw", 32'(r_w), 32'(!v.we));
            end else begin
                chk("ack", 32'(req_ack), 32'd1);
                chk("ack_berr", 32'(req_berr), 32'(v.exp_berr));
                chk("ack_rdat", 32'(req_rdat), 32'(v.exp_rdat));
                chk("ack_as", 32'(as_n), 32'd1);
                chk("ack_uds", 32'(uds_n), 32'd1);
                chk("ack_lds", 32'(lds_n), 32'd1);
                chk("ack_oe", 32'(data_oe), 32'd0);
                chk("ack_rw", 32'(r_w), 32'd1);
                chk("ack_adr", 32'(address), 32'(v.adr));
            end
        end
        if (!keep_req) req = 1'b0;
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_pulse", 32'(req_ack), 32'd0);
    endtask

    initial begin
        vec_t        tbl[6];
        vec_t        v;
        logic [15:0] rd_model;

        //            we    adr          bs     wdat      din       d  berr lat eb    rdat
        tbl[0] = '{1'b0, 23'h0BFE01, 2'b11, 16'h0000, 16'h1234, 0, 1'b0, 4, 1'b0, 16'h1234};
        tbl[1] = '{1'b1, 23'h000100, 2'b10, 16'hA5A5, 16'hFFFF, 3, 1'b0, 7, 1'b0, 16'h1234};
        tbl[2] = '{1'b0, 23'h7FFFFF, 2'b11, 16'h0000, 16'h5A5A, 0, 1'b1, 3, 1'b1, 16'h1234};
        tbl[3] = '{1'b0, 23'h000002, 2'b00, 16'h0000, 16'hBEEF, 1, 1'b0, 5, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b1, 23'h400000, 2'b01, 16'h0F0F, 16'h1111, 0, 1'b1, 3, 1'b1, 16'hBEEF};
        tbl[5] = '{1'b0, 23'h2AAAAA, 2'b01, 16'h0000, 16'hC3C3, 2, 1'b0, 6, 1'b0, 16'hC3C3};

        rst_n    = 1'b0;
        req      = 1'b0;
        req_we   = 1'b0;
        req_adr  = '0;
        req_bs   = '0;
        req_wdat = '0;
        data_in  = '0;
        dtack_n  = 1'b1;
        berr_n   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_berr", 32'(req_berr), 32'd0);
        chk("rst_rdat", 32'(req_rdat), 32'd0);
        chk("rst_as", 32'(as_n), 32'd1);
        chk("rst_uds", 32'(uds_n), 32'd1);
        chk("rst_lds", 32'(lds_n), 32'd1);
        chk("rst_rw", 32'(r_w), 32'd1);
        chk("rst_oe", 32'(data_oe), 32'd0);
        chk("rst_adr", 32'(address), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; tbl[1] is held across its ack to run back-to-back into tbl[2].
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i], (i == 1), 1'b0);
        end
        rd_model = 16'hC3C3;

        // Randomized cycles with model-derived expectations.
        for (int i = 0; i < 40; i++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.adr  = 23'($urandom);
            v.bs   = 2'($urandom);
            v.wdat = 16'($urandom);
            v.din  = 16'($urandom);
            v.d    = $urandom_range(0, 6);
            v.berr = ($urandom_range(0, 4) == 0);
            model(v, rd_model);
            run_txn(v, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        req = 1'b0;
        wait_tick();

        // _dtack held off for 1000 S4 ticks: waits throughout, or times out when enabled.
        v = '{1'b0, 23'h0DFF1C, 2'b11, 16'h0000, 16'h7777, 1000, 1'b0, 0, 1'b0, 16'h0000};
        model(v, rd_model);
        run_txn(v, 1'b0, 1'b0);

        // Reset pulsed while waiting in S4 aborts the cycle without an ack.
        req_we  = 1'b0;
        req_adr = 23'h123456;
        req_bs  = 2'b11;
        data_in = 16'h9999;
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        req     = 1'b1;
        wait_tick();
        wait_tick();
        wait_tick();
        chk("pre_rst_as", 32'(as_n), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_as", 32'(as_n), 32'd1);
        chk("mid_rst_uds", 32'(uds_n), 32'd1);
        chk("mid_rst_lds", 32'(lds_n), 32'd1);
        chk("mid_rst_rw", 32'(r_w), 32'd1);
        chk("mid_rst_oe", 32'(data_oe), 32'd0);
        chk("mid_rst_adr", 32'(address), 32'd0);
        chk("mid_rst_rdat", 32'(req_rdat), 32'd0);
        chk("mid_rst_ack", 32'(req_ack), 32'd0);
        req      = 1'b0;
        dtack_n  = 1'b0;
        rd_model = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            chk("post_rst_ack", 32'(req_ack), 32'd0);
            chk("post_rst_as", 32'(as_n), 32'd1);
        end
        v = '{1'b0, 23'h0BFE01, 2'b11, 16'h0000, 16'h4321, 1, 1'b0, 0, 1'b0, 16'h0000};
        model(v, rd_model);
        run_txn(v, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
